mem_result_checker: RTL and testbench

Parametrised, synthesizable-style result checker for CPU test benches. It sniffs the data-memory write bus and arms on a begin symbol written to a test port. Every distinct later write to that port is compared against an expected-value source indexed by result number; the block counts mismatches, measures cycles and raises `finish` after the last result. It replaces fixed-count, fixed-ROM checkers and supports any program length, data width and expected table.

---
 rtl/mem_result_checker_if.sv | 13 +
 rtl/mem_result_checker.sv | 116 +++++++++++
 tb/tb_mem_result_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_result_checker_if.sv
// Data-memory write bus sniffed by mem_result_checker.
// The CPU/bench side drives it as master; the checker observes it as slave.
interface mem_result_checker_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;

  modport master (output addr, data, wen);
  modport slave  (input  addr, data, wen);
endinterface

// File: rtl/mem_result_checker.sv
// Result checker: arms on a begin symbol at TEST_PORT, then compares each write against exp_data.
// Optional run timeout is enabled by defining CHECKER_TIMEOUT_EN.
module mem_result_checker #(
  parameter int unsigned        ADDR_W      = 30,
  parameter int unsigned        DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  TEST_PORT   = 'hFF,
  parameter logic [DATA_W-1:0]  BEGIN_SYM   = 'h00000168,
  parameter int unsigned        CHECK_NUM   = 33,
  parameter int unsigned        SWAP_BYTES  = 1,
  parameter int unsigned        ERR_W       = 8,
  parameter int unsigned        DUR_W       = 16,
  parameter int unsigned        TIMEOUT_CYC = 4096,
  parameter int unsigned        IDX_W       = $clog2(CHECK_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_result_checker_if.slave   bus,
  output logic [IDX_W-1:0]      exp_idx,
  input  logic [DATA_W-1:0]     exp_data,
  output logic [ERR_W-1:0]      error_num,
  output logic [DUR_W-1:0]      duration,
  output logic [IDX_W-1:0]      first_err_idx,
  output logic [DATA_W-1:0]     first_err_data,
  output logic                  timeout,
  output logic                  finish
);

  localparam logic [IDX_W-1:0] CNT_END  = IDX_W'(CHECK_NUM);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(CHECK_NUM - 1);
  // All-ones is the "not started" sentinel, so counting stops one below it.
  localparam logic [ERR_W-1:0] ERR_MAX  = ~ERR_W'(1);

  typedef enum logic [1:0] {StIdle, StCheck, StReport} state_e;

  state_e           state;
  logic             armed;
  logic [IDX_W-1:0] count;
  logic [DATA_W-1:0] sdata;
  logic             port_hit;
  logic             accept;
  logic             last_accept;
  logic             tmo_hit;

  if (SWAP_BYTES == 1) begin : g_swap
    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_byte
      assign sdata[8*i +: 8] = bus.data[DATA_W - 8*(i+1) +: 8];
    end
  end else begin : g_noswap
    assign sdata = bus.data;
  end

  assign port_hit    = bus.wen && (bus.addr == TEST_PORT);
  // armed drops after any write cycle, so a stalled multi-cycle write is seen once
  assign accept      = port_hit && armed;
  assign last_accept = accept && (count == CNT_LAST);

`ifdef CHECKER_TIMEOUT_EN
  assign tmo_hit = (duration >= DUR_W'(TIMEOUT_CYC));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  assign exp_idx = count;
  assign finish  = (state == StReport);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      armed          <= 1'b1;
      count          <= '0;
      error_num      <= '1;
      duration       <= '0;
      first_err_idx  <= '1;
      first_err_data <= '0;
      timeout        <= 1'b0;
    end else begin
      armed <= !bus.wen;
      unique case (state)
        StIdle: begin
          if (port_hit && (sdata == BEGIN_SYM)) begin
            state     <= StCheck;
            count     <= '0;
            error_num <= '0;
            duration  <= '0;
          end
        end
        StCheck: begin
          if (count == CNT_END) begin
            state <= StReport;
          end else if (tmo_hit && !last_accept) begin
            // A completing accept on the timeout edge wins over the timeout.
            state   <= StReport;
            timeout <= 1'b1;
          end else begin
            if (duration != '1) duration <= duration + 1'b1;
            if (accept) begin
              count <= count + 1'b1;
              if (sdata != exp_data) begin
                if (error_num != ERR_MAX) error_num <= error_num + 1'b1;
                if (error_num == '0) begin
                  first_err_idx  <= count;
                  first_err_data <= sdata;
                end
              end
            end
          end
        end
        StReport: ;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed self-checking bench for mem_result_checker (main 33-result DUT and a small
// ERR_W=2 / CHECK_NUM=5 instance for saturation).
module tb_mem_result_checker;

  localparam logic [29:0] PORT  = 30'hFF;
  localparam logic [31:0] BEGIN = 32'h00000168;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_result_checker_if #(.ADDR_W(30), .DATA_W(32)) bus  ();
  mem_result_checker_if #(.ADDR_W(30), .DATA_W(32)) bus2 ();

  logic [5:0]  exp_idx;
  logic [31:0] exp_data;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic [5:0]  first_err_idx;
  logic [31:0] first_err_data;
  logic        timeout, finish;

  logic [2:0]  exp_idx2;
  logic [31:0] exp_data2;
  logic [1:0]  error_num2;
  logic [15:0] duration2;
  logic [2:0]  first_err_idx2;
  logic [31:0] first_err_data2;
  logic        timeout2, finish2;

  logic [31:0] tbl [33];

  assign exp_data  = (exp_idx < 6'd33) ? tbl[exp_idx] : 32'h0;
  assign exp_data2 = 32'h0;

  mem_result_checker #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .exp_idx(exp_idx), .exp_data(exp_data), .error_num(error_num), .duration(duration),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .timeout(timeout), .finish(finish)
  );

  mem_result_checker #(.CHECK_NUM(5), .ERR_W(2), .TIMEOUT_CYC(100)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .exp_idx(exp_idx2), .exp_data(exp_data2), .error_num(error_num2), .duration(duration2),
    .first_err_idx(first_err_idx2), .first_err_data(first_err_data2),
    .timeout(timeout2), .finish(finish2)
  );

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Entered and left at posedge+1; value is given in readable order, bus carries it swapped.
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold);
    bus.addr = a; bus.data = bswap(d); bus.wen = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr2(input logic [29:0] a, input logic [31:0] d, input int hold);
    bus2.addr = a; bus2.data = bswap(d); bus2.wen = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus2.wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (error_num !== 8'hFF) begin errors++;
      $display("FAIL reset_error_num: got %h want ff", error_num); end
    checks++; if (exp_idx !== 6'd0) begin errors++;
      $display("FAIL reset_exp_idx: got %0d want 0", exp_idx); end
    checks++; if (duration !== 16'd0) begin errors++;
      $display("FAIL reset_duration: got %0d want 0", duration); end
    checks++; if (first_err_idx !== 6'h3F) begin errors++;
      $display("FAIL reset_first_err_idx: got %h want 3f", first_err_idx); end
    checks++; if (first_err_data !== 32'h0) begin errors++;
      $display("FAIL reset_first_err_data: got %h want 0", first_err_data); end
    checks++; if ({timeout, finish} !== 2'b00) begin errors++;
      $display("FAIL reset_flags: got %b want 00", {timeout, finish}); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ideal();
    do_reset();
    wr(PORT, BEGIN, 1);
    checks++; if (duration !== 16'd1 || error_num !== 8'd0 || exp_idx !== 6'd0) begin errors++;
      $display("FAIL ideal_start: got dur=%0d err=%0d idx=%0d want 1 0 0",
               duration, error_num, exp_idx); end
    for (int k = 0; k < 33; k++) wr(PORT, tbl[k], 1);
    checks++; if (finish !== 1'b1) begin errors++;
      $display("FAIL ideal_finish: got %b want 1", finish); end
    checks++; if (error_num !== 8'd0) begin errors++;
      $display("FAIL ideal_error_num: got %0d want 0", error_num); end
    checks++; if (first_err_idx !== 6'h3F) begin errors++;
      $display("FAIL ideal_first_err_idx: got %h want 3f", first_err_idx); end
    checks++; if (exp_idx !== 6'd33) begin errors++;
      $display("FAIL ideal_exp_idx: got %0d want 33", exp_idx); end
    checks++; if (duration !== 16'd66 || timeout !== 1'b0) begin errors++;
      $display("FAIL ideal_duration: got %0d/%b want 66/0", duration, timeout); end
  endtask

  task automatic test_corrupt();
    logic [31:0] d;
    do_reset();
    wr(PORT, BEGIN, 1);
    for (int k = 0; k < 33; k++) begin
      d = tbl[k];
      if (k == 5)  d = 32'd6;
      if (k == 20) d = tbl[k] ^ 32'h1;
      wr(PORT, d, 1);
    end
    checks++; if (error_num !== 8'd2) begin errors++;
      $display("FAIL corrupt_error_num: got %0d want 2", error_num); end
    checks++; if (first_err_idx !== 6'd5) begin errors++;
      $display("FAIL corrupt_first_err_idx: got %0d want 5", first_err_idx); end
    checks++; if (first_err_data !== 32'd6) begin errors++;
      $display("FAIL corrupt_first_err_data: got %h want 6", first_err_data); end
    checks++; if (finish !== 1'b1) begin errors++;
      $display("FAIL corrupt_finish: got %b want 1", finish); end
  endtask

  task automatic test_stall();
    do_reset();
    wr(PORT, BEGIN, 3);
    checks++; if (exp_idx !== 6'd0) begin errors++;
      $display("FAIL stall_begin_burst: got %0d want 0", exp_idx); end
    for (int k = 0; k < 33; k++) begin
      if (k == 10) begin
        checks++; if (exp_idx !== 6'd10) begin errors++;
          $display("FAIL stall_mid_idx: got %0d want 10", exp_idx); end
        wr(30'h10, tbl[k], 2);
        checks++; if (exp_idx !== 6'd10) begin errors++;
          $display("FAIL stall_other_addr: got %0d want 10", exp_idx); end
      end
      wr(PORT, tbl[k], 3);
    end
    checks++; if (exp_idx !== 6'd33 || error_num !== 8'd0 || finish !== 1'b1) begin errors++;
      $display("FAIL stall_end: got idx=%0d err=%0d fin=%b want 33 0 1",
               exp_idx, error_num, finish); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(PORT, BEGIN, 1);
    for (int k = 0; k < 10; k++) wr(PORT, tbl[k], 1);
    checks++; if (exp_idx !== 6'd10) begin errors++;
      $display("FAIL midrst_before: got %0d want 10", exp_idx); end
    #1 rst = 1'b1;
    #1;
    checks++; if (error_num !== 8'hFF || exp_idx !== 6'd0 || duration !== 16'd0) begin errors++;
      $display("FAIL midrst_async: got err=%h idx=%0d dur=%0d want ff 0 0",
               error_num, exp_idx, duration); end
    rst = 1'b0;
    @(posedge clk); #1;
    wr(PORT, tbl[0], 1);
    checks++; if (exp_idx !== 6'd0 || error_num !== 8'hFF) begin errors++;
      $display("FAIL midrst_idle: got idx=%0d err=%h want 0 ff", exp_idx, error_num); end
    wr(PORT, BEGIN, 1);
    for (int k = 0; k < 33; k++) wr(PORT, tbl[k], 1);
    checks++; if (error_num !== 8'd0 || finish !== 1'b1) begin errors++;
      $display("FAIL midrst_rerun: got err=%0d fin=%b want 0 1", error_num, finish); end
  endtask

  task automatic test_timeout();
    do_reset();
    wr(PORT, BEGIN, 1);
    for (int k = 0; k < 4; k++) wr(PORT, tbl[k], 1);
    repeat (150) @(posedge clk);
    #1;
    checks++; if (exp_idx !== 6'd4 || error_num !== 8'd0) begin errors++;
      $display("FAIL timeout_idx: got idx=%0d err=%0d want 4 0", exp_idx, error_num); end
`ifdef CHECKER_TIMEOUT_EN
    checks++; if (finish !== 1'b1 || timeout !== 1'b1) begin errors++;
      $display("FAIL timeout_flags: got fin=%b tmo=%b want 1 1", finish, timeout); end
    checks++; if (duration !== 16'd100) begin errors++;
      $display("FAIL timeout_duration: got %0d want 100", duration); end
`else
    checks++; if (finish !== 1'b0 || timeout !== 1'b0) begin errors++;
      $display("FAIL notimeout_flags: got fin=%b tmo=%b want 0 0", finish, timeout); end
    checks++; if (duration !== 16'd159) begin errors++;
      $display("FAIL notimeout_duration: got %0d want 159", duration); end
`endif
  endtask

  task automatic test_err_sat();
    do_reset();
    wr2(PORT, BEGIN, 1);
    wr2(PORT, 32'h1, 1);
    checks++; if (error_num2 !== 2'd1 || first_err_idx2 !== 3'd0 || first_err_data2 !== 32'h1)
    begin errors++;
      $display("FAIL sat_first: got err=%0d idx=%0d data=%h want 1 0 1",
               error_num2, first_err_idx2, first_err_data2); end
    for (int k = 1; k < 4; k++) wr2(PORT, 32'h1, 1);
    checks++; if (error_num2 !== 2'd2) begin errors++;
      $display("FAIL sat_error_num: got %0d want 2", error_num2); end
    bus2.data = bswap(32'h1); bus2.wen = 1'b1;
    @(posedge clk); #1 bus2.wen = 1'b0;
    checks++; if (exp_idx2 !== 3'd5 || finish2 !== 1'b0) begin errors++;
      $display("FAIL sat_last_accept: got idx=%0d fin=%b want 5 0", exp_idx2, finish2); end
    @(posedge clk); #1;
    checks++; if (finish2 !== 1'b1 || error_num2 !== 2'd2) begin errors++;
      $display("FAIL sat_finish: got fin=%b err=%0d want 1 2", finish2, error_num2); end
  endtask

  initial begin
    bus.addr = '0;  bus.data = '0;  bus.wen = 1'b0;
    bus2.addr = '0; bus2.data = '0; bus2.wen = 1'b0;
    tbl[0] = 32'd1;
    tbl[1] = 32'd1;
    for (int i = 2; i < 16; i++) tbl[i] = tbl[i-1] + tbl[i-2];
    for (int i = 0; i < 16; i++) tbl[16+i] = tbl[15-i];
    tbl[32] = 32'hFFFFFD5D;

    test_reset();
    test_ideal();
    test_corrupt();
    test_stall();
    test_mid_reset();
    test_timeout();
    test_err_sat();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
